// File: rtl/branch_resolve_unit.sv
// Branch condition resolver for the ID stage. It waits for forwarded operands
// with a bounded stall and keeps saturating statistics on resolved and taken branches.
module branch_resolve_unit #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 7
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [2:0]        i_mode,
  input  logic              i_operand_ready,
  input  logic [DATA_W-1:0] i_read_data_1,
  input  logic [DATA_W-1:0] i_read_data_2,
  input  logic              i_flush,
  output logic              o_taken,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_timeout,
  output logic [CNT_W-1:0]  o_branch_count,
  output logic [CNT_W-1:0]  o_taken_count
);

  // state | meaning
  // IDLE  | accepting a new branch request
  // WAIT  | mode latched, stalling ID until operands are final
  // DONE  | decision presented for one cycle on o_done/o_taken
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            state;
  logic [2:0]        mode_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        mode_sel;
  logic              taken_now;
  logic              resolve;

  function automatic logic eval_cond(input logic [2:0]        mode,
                                     input logic [DATA_W-1:0] rs,
                                     input logic [DATA_W-1:0] rt);
    logic rs_neg;
    logic rs_zero;
    rs_neg  = rs[DATA_W-1];
    rs_zero = (rs == '0);
    case (mode)
      3'b000:  eval_cond = (rs == rt);
      3'b001:  eval_cond = (rs != rt);
      3'b010:  eval_cond = rs_neg;
      3'b011:  eval_cond = !rs_neg;
      3'b100:  eval_cond = !rs_neg && !rs_zero;
      3'b101:  eval_cond = rs_neg || rs_zero;
      3'b110:  eval_cond = ($signed(rs) < $signed(rt));
      default: eval_cond = (rs < rt);
    endcase
  endfunction

  // Operands are always taken live; only the mode is held across the stall.
  always_comb begin
    mode_sel  = (state == ST_IDLE) ? i_mode : mode_q;
    taken_now = eval_cond(mode_sel, i_read_data_1, i_read_data_2);
    resolve   = !i_flush && i_operand_ready &&
                (((state == ST_IDLE) && i_valid) || (state == ST_WAIT));
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      mode_q    <= 3'b000;
      wait_cnt  <= '0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      if (i_flush) begin
        state    <= ST_IDLE;
        o_busy   <= 1'b0;
        wait_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_valid) begin
              mode_q   <= i_mode;
              wait_cnt <= '0;
              if (i_operand_ready) begin
                state  <= ST_DONE;
                o_done <= 1'b1;
              end else begin
                state  <= ST_WAIT;
                o_busy <= 1'b1;
              end
            end
          end
          ST_WAIT: begin
            if (i_operand_ready) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else if (wait_cnt == WAIT_LAST) begin
              state     <= ST_IDLE;
              o_busy    <= 1'b0;
              o_timeout <= 1'b1;
              wait_cnt  <= '0;
            end else begin
              wait_cnt <= wait_cnt + WAIT_ONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_taken        <= 1'b0;
      o_branch_count <= '0;
      o_taken_count  <= '0;
    end else if (resolve) begin
      o_taken <= taken_now;
      if (o_branch_count != '1)
        o_branch_count <= o_branch_count + CNT_ONE;
      if (taken_now && (o_taken_count != '1))
        o_taken_count <= o_taken_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a condition vector table plus
// hand-written stall, timeout, flush, reset and saturation sequences.
module tb_branch_resolve_unit;

  logic        clk;
  logic        reset_n;
  logic        valid;
  logic [2:0]  mode;
  logic        ready;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;

  logic        taken, done, busy, timeout;
  logic [15:0] bcnt, tcnt;
  logic        s_taken, s_done, s_busy, s_timeout;
  logic [3:0]  s_bcnt, s_tcnt;

  int errors = 0;
  int checks = 0;
  int exp_b  = 0;
  int exp_t  = 0;

  branch_resolve_unit #(.DATA_W(32), .CNT_W(16), .MAX_WAIT(7)) dut (
    .i_clk(clk), .i_reset(reset_n), .i_valid(valid), .i_mode(mode),
    .i_operand_ready(ready), .i_read_data_1(rs), .i_read_data_2(rt),
    .i_flush(flush), .o_taken(taken), .o_done(done), .o_busy(busy),
    .o_timeout(timeout), .o_branch_count(bcnt), .o_taken_count(tcnt)
  );

  branch_resolve_unit #(.DATA_W(32), .CNT_W(4), .MAX_WAIT(7)) dut_sat (
    .i_clk(clk), .i_reset(reset_n), .i_valid(valid), .i_mode(mode),
    .i_operand_ready(ready), .i_read_data_1(rs), .i_read_data_2(rt),
    .i_flush(flush), .o_taken(s_taken), .o_done(s_done), .o_busy(s_busy),
    .o_timeout(s_timeout), .o_branch_count(s_bcnt), .o_taken_count(s_tcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, " branch_count"}, 32'(bcnt), 32'(exp_b));
    check({tag, " taken_count"}, 32'(tcnt), 32'(exp_t));
    check({tag, " sat branch_count"}, 32'(s_bcnt), 32'(sat15(exp_b)));
    check({tag, " sat taken_count"}, 32'(s_tcnt), 32'(sat15(exp_t)));
  endtask

  task automatic do_branch(input string tag, input logic [2:0] m, input logic [31:0] a,
                           input logic [31:0] b, input logic exp_tk);
    valid = 1'b1; ready = 1'b1; mode = m; rs = a; rt = b;
    step();
    valid = 1'b0;
    exp_b++;
    if (exp_tk) exp_t++;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " taken"}, 32'(taken), 32'(exp_tk));
    check_counts(tag);
    step();
    check({tag, " done low after"}, 32'(done), 32'd0);
  endtask

  initial begin
    int busy_cycles;
    int to_pulses;
    int to_at;
    int done_seen;

    vecs[0]  = '{3'b000, 32'h0000_1234, 32'h0000_1234, 1'b1};
    vecs[1]  = '{3'b000, 32'h0000_0001, 32'h0000_0002, 1'b0};
    vecs[2]  = '{3'b001, 32'h0000_0001, 32'h0000_0002, 1'b1};
    vecs[3]  = '{3'b001, 32'h0000_0005, 32'h0000_0005, 1'b0};
    vecs[4]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[5]  = '{3'b010, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'b011, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{3'b011, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{3'b100, 32'h0000_0000, 32'h0000_0005, 1'b0};
    vecs[9]  = '{3'b100, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[10] = '{3'b101, 32'h0000_0000, 32'h0000_0009, 1'b1};
    vecs[11] = '{3'b101, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[12] = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[13] = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[14] = '{3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[15] = '{3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};

    reset_n = 1'b0; valid = 1'b0; mode = 3'b000; ready = 1'b0;
    rs = '0; rt = '0; flush = 1'b0;
    #12;
    check("reset taken", 32'(taken), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
    check_counts("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // condition table
    for (int i = 0; i < 16; i++)
      do_branch($sformatf("vec%0d", i), vecs[i].mode, vecs[i].rs, vecs[i].rt, vecs[i].exp_taken);

    // valid held through DONE is not queued; accepted again in the following IDLE
    valid = 1'b1; ready = 1'b1; mode = 3'b000; rs = 32'h3; rt = 32'h3;
    step();
    exp_b++; exp_t++;
    check("hold1 done", 32'(done), 32'd1);
    step();
    check("hold2 done ignored", 32'(done), 32'd0);
    check("hold2 branch_count", 32'(bcnt), 32'(exp_b));
    step();
    valid = 1'b0;
    exp_b++; exp_t++;
    check("hold3 done", 32'(done), 32'd1);
    check_counts("hold3");
    step();

    // stall with operand changing during WAIT
    valid = 1'b1; ready = 1'b0; mode = 3'b000; rs = 32'h5; rt = 32'h6;
    busy_cycles = 0;
    step();
    valid = 1'b0;
    if (busy) busy_cycles++;
    step();
    if (busy) busy_cycles++;
    rs = 32'h6;
    step();
    if (busy) busy_cycles++;
    ready = 1'b1;
    step();
    ready = 1'b0;
    exp_b++; exp_t++;
    check("stall busy cycles", 32'(busy_cycles), 32'd3);
    check("stall busy low at done", 32'(busy), 32'd0);
    check("stall done", 32'(done), 32'd1);
    check("stall taken live", 32'(taken), 32'd1);
    check_counts("stall");
    step();

    // timeout after MAX_WAIT cycles in WAIT
    valid = 1'b1; ready = 1'b0; mode = 3'b001; rs = 32'h1; rt = 32'h2;
    busy_cycles = 0; to_pulses = 0; to_at = -1; done_seen = 0;
    step();
    valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (busy) busy_cycles++;
      if (timeout) begin to_pulses++; to_at = c; end
      if (done) done_seen++;
      step();
    end
    check("timeout pulses", 32'(to_pulses), 32'd1);
    check("timeout cycle", 32'(to_at), 32'd7);
    check("timeout busy cycles", 32'(busy_cycles), 32'd7);
    check("timeout no done", 32'(done_seen), 32'd0);
    check_counts("timeout");

    // flush in WAIT beats ready
    valid = 1'b1; ready = 1'b0; mode = 3'b000; rs = 32'h7; rt = 32'h7;
    step();
    valid = 1'b0;
    check("flush busy in wait", 32'(busy), 32'd1);
    ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush wait done", 32'(done), 32'd0);
    check("flush wait busy", 32'(busy), 32'd0);
    step();
    ready = 1'b0;
    check("flush wait done later", 32'(done), 32'd0);
    check_counts("flush wait");

    // flush in IDLE beats valid+ready
    valid = 1'b1; ready = 1'b1; flush = 1'b1;
    step();
    valid = 1'b0; ready = 1'b0; flush = 1'b0;
    check("flush idle done", 32'(done), 32'd0);
    step();
    check("flush idle done later", 32'(done), 32'd0);
    check_counts("flush idle");

    // reset pulse in WAIT
    valid = 1'b1; ready = 1'b0; mode = 3'b000; rs = 32'h9; rt = 32'h9;
    step();
    valid = 1'b0;
    check("rstwait busy before", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    exp_b = 0; exp_t = 0;
    check("rstwait busy", 32'(busy), 32'd0);
    check("rstwait done", 32'(done), 32'd0);
    check("rstwait timeout", 32'(timeout), 32'd0);
    check("rstwait taken", 32'(taken), 32'd0);
    check_counts("rstwait");
    #2 reset_n = 1'b1;
    ready = 1'b1;
    step();
    check("rstwait no done", 32'(done), 32'd0);
    step();
    ready = 1'b0;
    check("rstwait no done 2", 32'(done), 32'd0);
    check_counts("rstwait after");

    // reset pulse in DONE
    valid = 1'b1; ready = 1'b1; mode = 3'b000; rs = 32'h1; rt = 32'h1;
    step();
    valid = 1'b0; ready = 1'b0;
    check("rstdone done before", 32'(done), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstdone done", 32'(done), 32'd0);
    check("rstdone branch_count", 32'(bcnt), 32'd0);
    #2 reset_n = 1'b1;
    step();
    check("rstdone no done", 32'(done), 32'd0);

    // saturation of the 4-bit counters
    for (int i = 0; i < 17; i++)
      do_branch($sformatf("sat%0d", i), 3'b000, 32'h0, 32'h0, 1'b1);
    check("sat final branch", 32'(s_bcnt), 32'hF);
    check("sat final taken", 32'(s_tcnt), 32'hF);
    check("wide final branch", 32'(bcnt), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DATA_W, default 32, is the operand width.
REQ-002 Parameter CNT_W, default 16, is the width of the statistics counters.
REQ-003 Parameter MAX_WAIT, default 7, is the maximum number of cycles spent waiting for operands before abort.
REQ-004 Port i_clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-005 Port i_reset, input, 1, is the reset: asynchronous, active-low.
REQ-006 Port i_valid, input, 1, is the branch request from the ID stage; sampled only in IDLE.
REQ-007 Port i_mode, input, 3, selects the condition: 000 EQ, 001 NE, 010 LTZ, 011 GEZ, 100 GTZ, 101 LEZ, 110 LT signed, 111 LTU.
REQ-008 Port i_operand_ready, input, 1, is asserted by the hazard/forwarding logic when the operands are final.
REQ-009 Port i_read_data_1, input, DATA_W, is operand rs.
REQ-010 Port i_read_data_2, input, DATA_W, is operand rt.
REQ-011 Port i_flush, input, 1, is the pipeline flush.
REQ-012 Port o_taken, output, 1, is the registered branch decision; valid only while o_done=1.
REQ-013 Port o_done, output, 1, is a one-cycle pulse marking the resolved decision.
REQ-014 Port o_busy, output, 1, is high in WAIT; the ID stage stalls on it.
REQ-015 Port o_timeout, output, 1, is a one-cycle pulse on wait abort.
REQ-016 Port o_branch_count, output, CNT_W, counts resolved branches.
REQ-017 Port o_taken_count, output, CNT_W, counts taken branches.

Function
REQ-018 FSM states SHALL be IDLE, WAIT and DONE, encoded in 2 bits.
REQ-019 IDLE with i_valid=1 and i_operand_ready=1: latch mode, evaluate, go to DONE; o_done rises next cycle (latency 1).
REQ-020 IDLE with i_valid=1 and i_operand_ready=0: latch i_mode, clear the wait counter, go to WAIT.
REQ-021 In WAIT the operands are NOT latched and the live i_read_data_1/2 are used; with i_operand_ready=1, evaluate using the latched mode and go to DONE.
REQ-022 WAIT counter increments each cycle without ready; at MAX_WAIT, go to IDLE, pulse o_timeout, do not pulse o_done, leave counters unchanged.
REQ-023 DONE lasts exactly one cycle with o_done=1, then returns to IDLE; a new i_valid is accepted only in the following IDLE cycle.
REQ-024 Conditions: EQ rs==rt; NE rs!=rt; LTZ rs<0 signed; GEZ rs>=0; GTZ rs>0; LEZ rs<=0; LT rs<rt signed; LTU rs<rt unsigned; modes 010-101 ignore rt.
REQ-025 o_taken SHALL hold its value outside DONE and is don't-care there; the bench checks it only with o_done.
REQ-026 On entry to DONE o_branch_count increments; o_taken_count increments if taken; both saturate at all-ones and never wrap.
REQ-027 i_flush=1 in any state forces IDLE next cycle, suppresses o_done/o_timeout and counter updates; flush has priority over ready, timeout and i_valid.
REQ-028 i_valid in WAIT or DONE is ignored (no queueing).

Reset
REQ-029 With i_reset=0, asynchronously: state IDLE, o_taken=0, o_done=0, o_busy=0, o_timeout=0, both counters 0, wait counter 0.
REQ-030 Reset asserted mid-WAIT or in DONE aborts the branch with no o_done pulse after release.

Verification
REQ-031 EQ, ready: valid=1, mode=000, rs=rt=0x0000_1234 -> o_done=1 and o_taken=1 next cycle; branch_count=1, taken_count=1.
REQ-032 Signed vs unsigned: rs=0xFFFF_FFFF, rt=0x1; mode 110 -> taken=1; mode 111 -> taken=0; mode 010 -> taken=1.
REQ-033 Stall: valid with ready=0 for 3 cycles, rs changes 0x5->0x6, ready=1 with rt=0x6, mode EQ -> o_busy high 3 cycles, o_done with taken=1 using the final value.
REQ-034 Timeout: MAX_WAIT=7, ready held 0 -> o_timeout pulses once after 7 WAIT cycles, IDLE next, counters unchanged.
REQ-035 Flush/reset: flush asserted in WAIT together with ready=1 -> no o_done; reset pulse in WAIT -> all outputs 0 immediately.
REQ-036 Saturation: CNT_W=4, 17 taken branches -> both counters read 0xF.
